constellation_capture_ctrl: RTL and testbench

Frame-synchronous capture controller for the constellation display path. It sits between the symbol synchroniser (clk_pixel domain) and a ping-pong dot memory. Accepted demodulated I/Q symbols are written into the capture bank while the renderer scans a stable display bank. At each frame boundary the controller swaps banks and publishes the captured dot count. It also applies symbol decimation, freeze and overflow dropping.

---
 rtl/constellation_capture_ctrl_if.sv | 40 ++++
 rtl/constellation_capture_ctrl.sv | 130 +++++++++++++
 tb/tb_constellation_capture_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/constellation_capture_ctrl_if.sv
// Symbol-in / dot-memory-out bundle for the constellation capture controller.
// Optional drop_cnt member exists only when CCTRL_DROP_CNT_EN is defined.
interface constellation_capture_ctrl_if #(
  parameter int MAX_DOTS = 64,
  parameter int ADDR_W   = $clog2(MAX_DOTS)
);
  logic [11:0]       sym_I;
  logic [11:0]       sym_Q;
  logic              sym_valid;
  logic              frame_start;
  logic [3:0]        decim;
  logic              freeze;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_I;
  logic [11:0]       wr_Q;
  logic              disp_bank;
  logic [ADDR_W:0]   disp_count;
  logic              busy_full;
`ifdef CCTRL_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  modport master (
    output sym_I, sym_Q, sym_valid, frame_start, decim, freeze,
    input  wr_en, wr_bank, wr_addr, wr_I, wr_Q, disp_bank, disp_count, busy_full
`ifdef CCTRL_DROP_CNT_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  sym_I, sym_Q, sym_valid, frame_start, decim, freeze,
    output wr_en, wr_bank, wr_addr, wr_I, wr_Q, disp_bank, disp_count, busy_full
`ifdef CCTRL_DROP_CNT_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/constellation_capture_ctrl.sv
// Ping-pong constellation dot capture: decimate, write capture bank, swap on frame_start.
// Writes land one cycle after acceptance; no backpressure, overflow drops. Option: CCTRL_DROP_CNT_EN.
module constellation_capture_ctrl #(
  parameter int MAX_DOTS = 64,
  parameter int ADDR_W   = $clog2(MAX_DOTS)
) (
  input logic                        clk_pixel,
  input logic                        rst,
  constellation_capture_ctrl_if.slave bus
);
  typedef enum logic [1:0] {SYNC, CAPTURE, FULL} state_t;

  localparam logic [ADDR_W:0] CAP_MAX = (ADDR_W+1)'(MAX_DOTS);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cap_count, cap_nxt, cap_base;
  logic [3:0]        dec_cnt, dec_nxt, dec_base;
  logic              disp_bank, disp_bank_nxt;
  logic [ADDR_W:0]   disp_count, disp_count_nxt;
  logic              wr_bank, wr_bank_nxt;
  logic              wr_en, wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
  logic [11:0]       wr_i, wr_i_nxt, wr_q, wr_q_nxt;
  logic              busy_full;
  logic              live, accept, drop, swap;
`ifdef CCTRL_DROP_CNT_EN
  logic [15:0]       drop_cnt, drop_nxt;
`endif

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      state      <= SYNC;
      cap_count  <= '0;
      dec_cnt    <= '0;
      disp_bank  <= 1'b1;
      disp_count <= '0;
      wr_bank    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_i       <= '0;
      wr_q       <= '0;
      busy_full  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cap_count  <= cap_nxt;
      dec_cnt    <= dec_nxt;
      disp_bank  <= disp_bank_nxt;
      disp_count <= disp_count_nxt;
      wr_bank    <= wr_bank_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_i       <= wr_i_nxt;
      wr_q       <= wr_q_nxt;
      busy_full  <= (state_nxt == FULL);
    end
  end

  always_comb begin
    state_nxt      = state;
    disp_bank_nxt  = disp_bank;
    disp_count_nxt = disp_count;
    wr_bank_nxt    = wr_bank;
    wr_en_nxt      = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_i_nxt       = wr_i;
    wr_q_nxt       = wr_q;
    cap_base       = cap_count;
    dec_base       = dec_cnt;
    live           = (state != SYNC);
    accept         = 1'b0;
    drop           = 1'b0;
    swap           = 1'b0;

    // frame_start resolves first so a coincident symbol is the new frame's first offer
    if (bus.frame_start) begin
      state_nxt = CAPTURE;
      cap_base  = '0;
      dec_base  = '0;
      live      = 1'b1;
      if (state != SYNC && !bus.freeze) begin
        swap           = 1'b1;
        disp_bank_nxt  = wr_bank;
        disp_count_nxt = cap_count;
        wr_bank_nxt    = ~wr_bank;
      end
    end

    cap_nxt = cap_base;
    dec_nxt = dec_base;

    if (bus.sym_valid && live) begin
      accept  = (dec_base == 4'd0);
      dec_nxt = (dec_base >= bus.decim) ? 4'd0 : dec_base + 4'd1;
      if (accept && state_nxt == CAPTURE) begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = cap_base[ADDR_W-1:0];
        wr_i_nxt    = bus.sym_I;
        wr_q_nxt    = bus.sym_Q;
        cap_nxt     = cap_base + 1'b1;
        if (cap_nxt == CAP_MAX) state_nxt = FULL;
      end else if (accept) begin
        drop = 1'b1;
      end
    end
  end

`ifdef CCTRL_DROP_CNT_EN
  always_comb begin
    drop_nxt = drop_cnt;
    if (swap)                          drop_nxt = '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_nxt = drop_cnt + 16'd1;
  end

  always_ff @(posedge clk_pixel) begin
    if (rst) drop_cnt <= '0;
    else     drop_cnt <= drop_nxt;
  end

  assign bus.drop_cnt = drop_cnt;
`endif

  assign bus.wr_en      = wr_en;
  assign bus.wr_bank    = wr_bank;
  assign bus.wr_addr    = wr_addr;
  assign bus.wr_I       = wr_i;
  assign bus.wr_Q       = wr_q;
  assign bus.disp_bank  = disp_bank;
  assign bus.disp_count = disp_count;
  assign bus.busy_full  = busy_full;
endmodule

// File: tb/tb_constellation_capture_ctrl.sv
// Directed bench for constellation_capture_ctrl with hand-computed expectations.
module tb_constellation_capture_ctrl;
  localparam int MAX_DOTS = 64;
  localparam int ADDR_W   = $clog2(MAX_DOTS);

  logic clk_pixel = 1'b0;
  logic rst       = 1'b1;
  int   n_chk     = 0;
  int   n_pass    = 0;
  int   wr_cnt    = 0;
  int   base;

  constellation_capture_ctrl_if #(.MAX_DOTS(MAX_DOTS)) bus ();

  constellation_capture_ctrl #(.MAX_DOTS(MAX_DOTS)) dut (
    .clk_pixel (clk_pixel),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  always @(negedge clk_pixel) if (bus.wr_en) wr_cnt = wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic offer(input logic [11:0] i_val, input logic [11:0] q_val);
    bus.sym_I = i_val;
    bus.sym_Q = q_val;
    bus.sym_valid = 1'b1;
    step();
    bus.sym_valid = 1'b0;
  endtask

  task automatic frame(input logic frz);
    bus.freeze = frz;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    bus.freeze = 1'b0;
  endtask

  initial begin
    bus.sym_I = '0; bus.sym_Q = '0; bus.sym_valid = 1'b0;
    bus.frame_start = 1'b0; bus.decim = 4'd0; bus.freeze = 1'b0;
    step(); step();
    chk("rst_wr_en",      32'(bus.wr_en),      0);
    chk("rst_wr_bank",    32'(bus.wr_bank),    0);
    chk("rst_wr_addr",    32'(bus.wr_addr),    0);
    chk("rst_wr_I",       32'(bus.wr_I),       0);
    chk("rst_disp_bank",  32'(bus.disp_bank),  1);
    chk("rst_disp_count", 32'(bus.disp_count), 0);
    chk("rst_busy_full",  32'(bus.busy_full),  0);
`ifdef CCTRL_DROP_CNT_EN
    chk("rst_drop_cnt",   32'(bus.drop_cnt),   0);
`endif
    rst = 1'b0;

    // symbols before the first frame_start are ignored
    base = wr_cnt;
    for (int k = 0; k < 5; k++) begin offer(12'(k + 1), 12'h7FF); step(); end
    chk("sync_no_writes", 32'(wr_cnt - base), 0);
    frame(1'b0);
    chk("sync_fs_disp_bank",  32'(bus.disp_bank),  1);
    chk("sync_fs_disp_count", 32'(bus.disp_count), 0);
    chk("sync_fs_wr_bank",    32'(bus.wr_bank),    0);

    // three symbols, every one kept
    for (int k = 0; k < 3; k++) begin
      offer(12'(100 + k), 12'hF00 + 12'(k));
      chk("cap_wr_en",   32'(bus.wr_en),   1);
      chk("cap_wr_addr", 32'(bus.wr_addr), 32'(k));
      chk("cap_wr_bank", 32'(bus.wr_bank), 0);
      chk("cap_wr_I",    32'(bus.wr_I),    32'(100 + k));
      chk("cap_wr_Q",    32'(bus.wr_Q),    32'(12'hF00 + k));
      step();
      chk("cap_wr_en_pulse", 32'(bus.wr_en), 0);
    end
    frame(1'b0);
    chk("swap1_disp_bank",  32'(bus.disp_bank),  0);
    chk("swap1_disp_count", 32'(bus.disp_count), 3);
    chk("swap1_wr_bank",    32'(bus.wr_bank),    1);

    // 70 back-to-back symbols overflow a 64-entry bank
    base = wr_cnt;
    bus.sym_valid = 1'b1;
    for (int k = 0; k < 70; k++) begin
      bus.sym_I = 12'(k);
      step();
      if (k == 62) chk("full_busy_before", 32'(bus.busy_full), 0);
      if (k == 63) begin
        chk("full_busy_rise", 32'(bus.busy_full), 1);
        chk("full_last_addr", 32'(bus.wr_addr),   63);
      end
      if (k == 64) chk("full_drop_no_wr", 32'(bus.wr_en), 0);
    end
    bus.sym_valid = 1'b0;
    step();
    chk("full_writes", 32'(wr_cnt - base), 64);
    chk("full_busy",   32'(bus.busy_full), 1);
`ifdef CCTRL_DROP_CNT_EN
    chk("full_drop_cnt", 32'(bus.drop_cnt), 6);
`endif
    frame(1'b0);
    chk("swap2_disp_count", 32'(bus.disp_count), 64);
    chk("swap2_disp_bank",  32'(bus.disp_bank),  1);
    chk("swap2_busy",       32'(bus.busy_full),  0);
    chk("swap2_wr_bank",    32'(bus.wr_bank),    0);
`ifdef CCTRL_DROP_CNT_EN
    chk("swap2_drop_clr",   32'(bus.drop_cnt),   0);
`endif

    // decim = 2 keeps offers 0,3,6,9
    bus.decim = 4'd2;
    base = wr_cnt;
    for (int k = 0; k < 9; k++) begin offer(12'(k), 12'(k)); step(); end
    chk("decim_writes",    32'(wr_cnt - base), 3);
    chk("decim_last_addr", 32'(bus.wr_addr),   2);
    chk("decim_last_I",    32'(bus.wr_I),      6);
    offer(12'd9, 12'd9);
    chk("decim_off9_wr", 32'(bus.wr_en), 1);
    offer(12'd10, 12'd10);
    chk("decim_off10_skip", 32'(bus.wr_en), 0);
    frame(1'b0);
    chk("swap3_disp_count", 32'(bus.disp_count), 4);
    chk("swap3_disp_bank",  32'(bus.disp_bank),  0);
    offer(12'd55, 12'd55);
    chk("decim_new_frame_wr",   32'(bus.wr_en),   1);
    chk("decim_new_frame_addr", 32'(bus.wr_addr), 0);
    chk("decim_new_frame_bank", 32'(bus.wr_bank), 1);

    // freeze holds the display bank and restarts capture in the same bank
    bus.decim = 4'd0;
    frame(1'b0);
    chk("swap4_disp_bank",  32'(bus.disp_bank),  1);
    chk("swap4_disp_count", 32'(bus.disp_count), 1);
    for (int k = 0; k < 4; k++) begin offer(12'(200 + k), 12'd0); step(); end
    chk("frz_pre_addr", 32'(bus.wr_addr), 3);
    frame(1'b1);
    chk("frz_disp_bank",  32'(bus.disp_bank),  1);
    chk("frz_disp_count", 32'(bus.disp_count), 1);
    chk("frz_wr_bank",    32'(bus.wr_bank),    0);
    offer(12'd300, 12'd301);
    chk("frz_next_addr", 32'(bus.wr_addr), 0);
    chk("frz_next_bank", 32'(bus.wr_bank), 0);
    chk("frz_next_wr",   32'(bus.wr_en),   1);

    // frame_start and sym_valid together
    offer(12'd1, 12'd1);
    offer(12'd2, 12'd2);
    bus.sym_I = 12'hABC; bus.sym_Q = 12'h123;
    bus.sym_valid = 1'b1; bus.frame_start = 1'b1;
    step();
    bus.sym_valid = 1'b0; bus.frame_start = 1'b0;
    chk("sim_disp_bank",  32'(bus.disp_bank),  0);
    chk("sim_disp_count", 32'(bus.disp_count), 3);
    chk("sim_wr_bank",    32'(bus.wr_bank),    1);
    chk("sim_wr_en",      32'(bus.wr_en),      1);
    chk("sim_wr_addr",    32'(bus.wr_addr),    0);
    chk("sim_wr_I",       32'(bus.wr_I),       32'h0ABC);

    // reset in the cycle of an accepted symbol cancels the write
    bus.sym_I = 12'h111; bus.sym_valid = 1'b1; rst = 1'b1;
    step();
    bus.sym_valid = 1'b0; rst = 1'b0;
    chk("rst_mid_wr_en",     32'(bus.wr_en),      0);
    chk("rst_mid_disp_bank", 32'(bus.disp_bank),  1);
    chk("rst_mid_count",     32'(bus.disp_count), 0);
    chk("rst_mid_wr_bank",   32'(bus.wr_bank),    0);
    offer(12'h222, 12'h222);
    chk("rst_sync_ignore", 32'(bus.wr_en), 0);

    // coincident symbol in SYNC is captured at address 0
    bus.sym_I = 12'h345; bus.sym_valid = 1'b1; bus.frame_start = 1'b1;
    step();
    bus.sym_valid = 1'b0; bus.frame_start = 1'b0;
    chk("sync_sim_wr_en",     32'(bus.wr_en),     1);
    chk("sync_sim_wr_addr",   32'(bus.wr_addr),   0);
    chk("sync_sim_wr_bank",   32'(bus.wr_bank),   0);
    chk("sync_sim_disp_bank", 32'(bus.disp_bank), 1);
    chk("sync_sim_wr_I",      32'(bus.wr_I),      32'h0345);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
